stage_m: RTL and testbench

//  Memory stage, directly downstream of EX. Forms effective address, drives the data-memory

---
 rtl/stage_m_pkg.sv | 73 +++++++
 rtl/stage_m_if.sv | 23 ++
 rtl/stage_m_load_align.sv | 35 +++
 rtl/stage_m.sv | 152 +++++++++++++++
 tb/tb_stage_m.sv | 258 +++++++++++++++++++++++++
 5 files changed

// File: rtl/stage_m_pkg.sv
// Shared definitions for the memory stage.
// Contents: opcode classes, the default exception vector, the FSM state encoding,
// access size encoding, the latched-access record, and small decode helpers
// for alignment, byte enables and store-lane replication.
package stage_m_pkg;

  localparam logic [31:0] EXC_VECTOR_DEF = 32'hBFC00380;

  // Primary opcode classes, taken from opcode[5:3].
  localparam logic [2:0] OPC_LOAD  = 3'b100;
  localparam logic [2:0] OPC_STORE = 3'b101;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_REQ  = 2'd1,
    ST_DATA = 2'd2
  } state_t;

  typedef enum logic [1:0] {
    SZ_BYTE = 2'd0,
    SZ_HALF = 2'd1,
    SZ_WORD = 2'd2
  } size_t;

  // Everything about an accepted access that must survive the stall.
  typedef struct packed {
    logic [29:0] addr;
    logic        we;
    logic [3:0]  be;
    logic [31:0] wdata;
    logic [5:0]  wbr;
    size_t       size;
    logic        sgn;
    logic [1:0]  off;
    logic [31:0] pc;
  } acc_t;

  // opcode[1:0]: 00 byte, 01 half, anything else is treated as a word access.
  function automatic size_t op_size(input logic [5:0] op);
    case (op[1:0])
      2'b00:   return SZ_BYTE;
      2'b01:   return SZ_HALF;
      default: return SZ_WORD;
    endcase
  endfunction

  function automatic logic misaligned(input size_t sz, input logic [1:0] off);
    case (sz)
      SZ_HALF: return off[0];
      SZ_WORD: return |off;
      default: return 1'b0;
    endcase
  endfunction

  // Big-endian lanes: offset 0 is byte lane 3 (bits 31:24).
  function automatic logic [3:0] byte_en(input size_t sz, input logic [1:0] off);
    case (sz)
      SZ_BYTE: return 4'b1000 >> off;
      SZ_HALF: return off[1] ? 4'b0011 : 4'b1100;
      default: return 4'b1111;
    endcase
  endfunction

  // Store data replicated on every lane so the enables alone pick the bytes.
  function automatic logic [31:0] lane_data(input size_t sz, input logic [31:0] v);
    case (sz)
      SZ_BYTE: return {4{v[7:0]}};
      SZ_HALF: return {2{v[15:0]}};
      default: return v;
    endcase
  endfunction

endpackage

// File: rtl/stage_m_if.sv
// Data-memory port bundle between the memory stage and data memory.
// master: memory stage (drives addr/req/we/be/wdata, samples wait/rdata/rvalid).
// slave : data memory (the reverse).
interface stage_m_if;
  logic [29:0] dmem_addr;
  logic        dmem_req;
  logic        dmem_we;
  logic [3:0]  dmem_be;
  logic [31:0] dmem_wdata;
  logic        dmem_wait;
  logic [31:0] dmem_rdata;
  logic        dmem_rvalid;

  modport master (
    output dmem_addr, dmem_req, dmem_we, dmem_be, dmem_wdata,
    input  dmem_wait, dmem_rdata, dmem_rvalid
  );

  modport slave (
    input  dmem_addr, dmem_req, dmem_we, dmem_be, dmem_wdata,
    output dmem_wait, dmem_rdata, dmem_rvalid
  );
endinterface

// File: rtl/stage_m_load_align.sv
// Load data alignment, purely combinational.
// Ports: off   - ea[1:0] of the access
//        size  - byte/half/word
//        sgn   - 1 = sign-extend, 0 = zero-extend
//        rdata - raw memory word (big-endian lanes)
//        res   - aligned, extended 32-bit result
module stage_m_load_align
  import stage_m_pkg::*;
(
  input  logic [1:0]  off,
  input  size_t       size,
  input  logic        sgn,
  input  logic [31:0] rdata,
  output logic [31:0] res
);

  logic [3:0][7:0] lanes;
  logic [7:0]      b;
  logic [15:0]     h;

  assign lanes = rdata;
  // Lane index is 3-off, which for two bits is simply ~off.
  assign b = lanes[~off];
  assign h = off[1] ? rdata[15:0] : rdata[31:16];

  always_comb begin
    res = rdata;
    case (size)
      SZ_BYTE: res = {{24{sgn & b[7]}}, b};
      SZ_HALF: res = {{16{sgn & h[15]}}, h};
      default: res = rdata;
    endcase
  end

endmodule

// File: rtl/stage_m.sv
// Memory stage, directly downstream of EX.
// Forms the effective address, runs the data-memory handshake for loads and
// stores, aligns load data and otherwise forwards the ALU result. Misaligned
// valid accesses raise an address-error restart to EXC_VECTOR.
// Ports:
//   clock, rst          - clock (rising edge), async active-high reset
//   x_*                 - EX stage results (ignored while m_stall=1)
//   dmem                - data-memory port (stage_m_if.master)
//   m_valid/m_wbr/m_res - result for writeback / EX hazard logic
//   m_pc                - PC of the instruction producing the result
//   m_restart(_pc)      - restart request and target
//   m_flush             - flush younger stages on exception
//   m_badvaddr          - faulting address of the last address error
//   m_stall             - hold upstream while an access is outstanding
module stage_m
  import stage_m_pkg::*;
#(
  parameter logic [31:0] EXC_VECTOR = EXC_VECTOR_DEF
) (
  input  logic              clock,
  input  logic              rst,
  input  logic              x_valid,
  input  logic [31:0]       x_instr,
  input  logic [31:0]       x_pc,
  input  logic [5:0]        x_opcode,
  input  logic [31:0]       x_op1_val,
  input  logic [31:0]       x_rt_val,
  input  logic [5:0]        x_wbr,
  input  logic [31:0]       x_res,
  input  logic              x_restart,
  input  logic [31:0]       x_restart_pc,
  stage_m_if.master         dmem,
  output logic              m_valid,
  output logic [5:0]        m_wbr,
  output logic [31:0]       m_res,
  output logic [31:0]       m_pc,
  output logic              m_restart,
  output logic [31:0]       m_restart_pc,
  output logic              m_flush,
  output logic [31:0]       m_badvaddr,
  output logic              m_stall
);

  state_t      state;
  acc_t        acc;
  logic        is_ld, is_st, is_mem, mis;
  logic [31:0] ea;
  size_t       sz;
  logic [31:0] ld_res;
  logic        unused_instr;

  // Decode of the incoming EX result.
  assign is_ld        = (x_opcode[5:3] == OPC_LOAD);
  assign is_st        = (x_opcode[5:3] == OPC_STORE);
  assign is_mem       = is_ld | is_st;
  assign ea           = x_op1_val + {{16{x_instr[15]}}, x_instr[15:0]};
  assign sz           = op_size(x_opcode);
  assign mis          = misaligned(sz, ea[1:0]);
  assign unused_instr = ^x_instr[31:16];

  stage_m_load_align u_align (
    .off   (acc.off),
    .size  (acc.size),
    .sgn   (acc.sgn),
    .rdata (dmem.dmem_rdata),
    .res   (ld_res)
  );

  // Port is driven straight from the latched access so it stays stable under wait.
  assign dmem.dmem_addr  = acc.addr;
  assign dmem.dmem_req   = (state == ST_REQ);
  assign dmem.dmem_we    = acc.we;
  assign dmem.dmem_be    = acc.be;
  assign dmem.dmem_wdata = acc.wdata;
  assign m_stall         = (state != ST_IDLE);

  always_ff @(posedge clock or posedge rst) begin
    if (rst) begin
      state        <= ST_IDLE;
      acc          <= '0;
      m_valid      <= 1'b0;
      m_wbr        <= '0;
      m_res        <= '0;
      m_pc         <= '0;
      m_restart    <= 1'b0;
      m_restart_pc <= '0;
      m_flush      <= 1'b0;
      m_badvaddr   <= '0;
    end else begin
      // Single-cycle pulses; only IDLE may pass a restart or a result through.
      m_valid   <= 1'b0;
      m_restart <= 1'b0;
      m_flush   <= 1'b0;
      case (state)
        ST_IDLE: begin
          m_pc <= x_pc;
          if (x_valid && is_mem && mis) begin
            // Address error wins over any restart EX asked for.
            m_wbr        <= '0;
            m_restart    <= 1'b1;
            m_restart_pc <= EXC_VECTOR;
            m_flush      <= 1'b1;
            m_badvaddr   <= ea;
          end else if (x_valid && is_mem) begin
            acc.addr  <= ea[31:2];
            acc.we    <= is_st;
            acc.be    <= byte_en(sz, ea[1:0]);
            acc.wdata <= lane_data(sz, x_rt_val);
            acc.wbr   <= x_wbr;
            acc.size  <= sz;
            acc.sgn   <= ~x_opcode[2];
            acc.off   <= ea[1:0];
            acc.pc    <= x_pc;
            m_wbr     <= '0;
            state     <= ST_REQ;
          end else begin
            // Non-memory op, or an invalid memory op that issues nothing.
            m_valid      <= x_valid;
            m_wbr        <= x_wbr;
            m_res        <= x_res;
            m_restart    <= x_restart;
            m_restart_pc <= x_restart_pc;
          end
        end
        ST_REQ: begin
          // Any rvalid seen here is ignored; data follows acceptance.
          if (!dmem.dmem_wait) begin
            if (acc.we) begin
              m_valid <= 1'b1;
              m_wbr   <= '0;
              m_pc    <= acc.pc;
              state   <= ST_IDLE;
            end else begin
              state <= ST_DATA;
            end
          end
        end
        ST_DATA: begin
          if (dmem.dmem_rvalid) begin
            m_res   <= ld_res;
            m_valid <= 1'b1;
            m_wbr   <= acc.wbr;
            m_pc    <= acc.pc;
            state   <= ST_IDLE;
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_stage_m.sv
module tb_stage_m;

  localparam logic [5:0] LB = 6'h20, LH = 6'h21, LW = 6'h23, LBU = 6'h24, LHU = 6'h25;
  localparam logic [5:0] SB = 6'h28, SH = 6'h29, SW = 6'h2B, ADDU = 6'h00, BEQ = 6'h04;
  localparam logic [31:0] EXCV = 32'hBFC00380;

  typedef struct {
    logic [5:0]  op;
    logic [31:0] base;
    logic [15:0] imm;
    logic [31:0] rt;
    logic [5:0]  wbr;
    logic [31:0] res;
    logic        valid;
    logic        restart;
    logic [31:0] rpc;
    logic [31:0] rdata;
    int          waits;
    logic        early_rv;
    logic        exc;
    logic [31:0] exp_res;   // badvaddr when exc=1
    logic [3:0]  exp_be;
    logic [31:0] exp_wdata;
  } vec_t;

  logic clock = 1'b0;
  logic rst;
  logic x_valid, x_restart;
  logic [31:0] x_instr, x_pc, x_op1_val, x_rt_val, x_res, x_restart_pc;
  logic [5:0] x_opcode, x_wbr;
  logic m_valid, m_restart, m_flush, m_stall;
  logic [5:0] m_wbr;
  logic [31:0] m_res, m_pc, m_restart_pc, m_badvaddr;

  int checks = 0;
  int errors = 0;

  always #5 clock = ~clock;

  stage_m_if dmem ();

  stage_m dut (
    .clock(clock), .rst(rst),
    .x_valid(x_valid), .x_instr(x_instr), .x_pc(x_pc), .x_opcode(x_opcode),
    .x_op1_val(x_op1_val), .x_rt_val(x_rt_val), .x_wbr(x_wbr), .x_res(x_res),
    .x_restart(x_restart), .x_restart_pc(x_restart_pc),
    .dmem(dmem),
    .m_valid(m_valid), .m_wbr(m_wbr), .m_res(m_res), .m_pc(m_pc),
    .m_restart(m_restart), .m_restart_pc(m_restart_pc), .m_flush(m_flush),
    .m_badvaddr(m_badvaddr), .m_stall(m_stall)
  );

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h required=%h", name, act, exp);
    end
  endtask

  task automatic idle_x();
    x_valid = 0; x_restart = 0; x_opcode = ADDU; x_instr = 0; x_pc = 0;
    x_op1_val = 0; x_rt_val = 0; x_wbr = 0; x_res = 0; x_restart_pc = 0;
  endtask

  function automatic bit is_load(input logic [5:0] op);
    return op inside {LB, LH, LW, LBU, LHU};
  endfunction
  function automatic bit is_store(input logic [5:0] op);
    return op inside {SB, SH, SW};
  endfunction

  // Reference: expected result from the access rules, with plain arithmetic.
  function automatic vec_t model(input vec_t v);
    vec_t r;
    int unsigned ea, off, n, sh;
    longint unsigned val, full;
    r = v;
    ea = v.base + 32'($signed(v.imm));
    off = ea % 4;
    n = (v.op inside {LB, LBU, SB}) ? 1 : (v.op inside {LH, LHU, SH}) ? 2 : 4;
    r.exc = v.valid && (is_load(v.op) || is_store(v.op)) && (ea % n != 0);
    r.exp_res = v.res; r.exp_be = 0; r.exp_wdata = 0;
    if (r.exc) r.exp_res = ea;
    else if (is_load(v.op)) begin
      sh = 8 * (4 - off - n);
      full = 64'd1 << (8 * n);
      val = (longint'(v.rdata) >> sh) % full;
      if ((v.op == LB || v.op == LH) && val >= full / 2) val = val - full;
      r.exp_res = 32'(val);
    end else if (is_store(v.op)) begin
      r.exp_be = 4'(((1 << n) - 1) << (4 - off - n));
      r.exp_wdata = (n == 1) ? (v.rt % 256) * 32'h01010101 :
                    (n == 2) ? (v.rt % 65536) * 32'h00010001 : v.rt;
    end
    return r;
  endfunction

  task automatic apply(input vec_t v, input logic [31:0] pc);
    logic [31:0] ea;
    int gap;
    ea = v.base + {{16{v.imm[15]}}, v.imm};
    x_valid = v.valid; x_instr = {16'hC0DE, v.imm}; x_pc = pc; x_opcode = v.op;
    x_op1_val = v.base; x_rt_val = v.rt; x_wbr = v.wbr; x_res = v.res;
    x_restart = v.restart; x_restart_pc = v.rpc;
    dmem.dmem_wait = (v.waits > 0); dmem.dmem_rvalid = 0; dmem.dmem_rdata = 32'hBADBAD00;
    @(posedge clock); @(negedge clock);
    if (!(v.valid && (is_load(v.op) || is_store(v.op))) || v.exc) begin
      idle_x();
      chk("no_req", dmem.dmem_req, 0);
      chk("stall_idle", m_stall, 0);
      chk("valid_pass", m_valid, v.valid && !v.exc);
      chk("restart", m_restart, v.exc | v.restart);
      chk("restart_pc", m_restart_pc, v.exc ? EXCV : v.rpc);
      chk("flush", m_flush, v.exc);
      if (v.exc) chk("badvaddr", m_badvaddr, v.exp_res);
      else if (v.valid) begin
        chk("res_pass", m_res, v.exp_res);
        chk("wbr_pass", m_wbr, v.wbr);
        chk("pc_pass", m_pc, pc);
      end
    end else begin
      // Upstream junk while stalled must be ignored.
      x_valid = 1; x_opcode = ADDU; x_res = 32'hFFFFFFFF; x_restart = 1;
      x_restart_pc = 32'h0BAD0BAD; x_wbr = 6'd31;
      chk("req", dmem.dmem_req, 1);
      chk("addr", {2'b0, dmem.dmem_addr}, {2'b0, ea[31:2]});
      chk("we", dmem.dmem_we, is_store(v.op));
      chk("stall_busy", m_stall, 1);
      chk("valid_busy", m_valid, 0);
      if (is_store(v.op)) begin
        chk("be", dmem.dmem_be, v.exp_be);
        chk("wdata", dmem.dmem_wdata, v.exp_wdata);
      end
      dmem.dmem_rvalid = v.early_rv && (v.waits == 0);
      for (int k = 1; k <= v.waits; k++) begin
        @(posedge clock); @(negedge clock);
        chk("req_hold", dmem.dmem_req, 1);
        chk("addr_hold", {2'b0, dmem.dmem_addr}, {2'b0, ea[31:2]});
        chk("restart_stalled", m_restart, 0);
        dmem.dmem_wait = (k < v.waits);
        dmem.dmem_rvalid = v.early_rv && (k == v.waits);
      end
      @(posedge clock); @(negedge clock);
      dmem.dmem_wait = 0; dmem.dmem_rvalid = 0;
      if (is_store(v.op)) begin
        idle_x();
        chk("st_valid", m_valid, 1);
        chk("st_wbr", m_wbr, 0);
        chk("st_stall", m_stall, 0);
        chk("st_req_drop", dmem.dmem_req, 0);
        chk("st_pc", m_pc, pc);
      end else begin
        chk("ld_req_drop", dmem.dmem_req, 0);
        chk("ld_stall", m_stall, 1);
        chk("ld_no_early", m_valid, 0);
        gap = $urandom_range(0, 2);
        repeat (gap) begin
          @(posedge clock); @(negedge clock);
          chk("ld_wait_valid", m_valid, 0);
        end
        dmem.dmem_rdata = v.rdata; dmem.dmem_rvalid = 1;
        @(posedge clock); @(negedge clock);
        dmem.dmem_rvalid = 0;
        idle_x();
        chk("ld_valid", m_valid, 1);
        chk("ld_res", m_res, v.exp_res);
        chk("ld_wbr", m_wbr, v.wbr);
        chk("ld_stall_drop", m_stall, 0);
        chk("ld_restart", m_restart, 0);
        chk("ld_pc", m_pc, pc);
      end
    end
  endtask

  vec_t tbl[15];
  logic [5:0] ops[10];

  initial begin
    #200000;
    $display("FAIL watchdog time limit reached");
    $fatal(1);
  end

  initial begin
    vec_t v;
    //           op    base          imm       rt            wbr  res   vl rs rpc          rdata          w  er exc exp_res        be       wdata
    tbl[0]  = '{LW,   32'h100, 16'h0008, 32'h0,        6'd5,  32'd0, 1, 0, 32'h0,  32'h11223344, 2, 0, 0, 32'h11223344, 4'h0,    32'h0};
    tbl[1]  = '{LB,   32'h100, 16'h0003, 32'h0,        6'd6,  32'd0, 1, 0, 32'h0,  32'h000000F0, 0, 0, 0, 32'hFFFFFFF0, 4'h0,    32'h0};
    tbl[2]  = '{LBU,  32'h100, 16'h0003, 32'h0,        6'd7,  32'd0, 1, 0, 32'h0,  32'h000000F0, 3, 0, 0, 32'h000000F0, 4'h0,    32'h0};
    tbl[3]  = '{SH,   32'h100, 16'h0002, 32'hABCD,     6'd9,  32'd0, 1, 0, 32'h0,  32'h0,        1, 0, 0, 32'h0,        4'b0011, 32'hABCDABCD};
    tbl[4]  = '{LW,   32'h100, 16'h0002, 32'h0,        6'd5,  32'd0, 1, 1, 32'h77, 32'h0,        0, 0, 1, 32'h102,      4'h0,    32'h0};
    tbl[5]  = '{ADDU, 32'h0,   16'h0000, 32'h0,        6'd3,  32'd7, 1, 0, 32'h0,  32'h0,        0, 0, 0, 32'd7,        4'h0,    32'h0};
    tbl[6]  = '{BEQ,  32'h0,   16'h0000, 32'h0,        6'd0,  32'd0, 1, 1, 32'h40, 32'h0,        0, 0, 0, 32'd0,        4'h0,    32'h0};
    tbl[7]  = '{LH,   32'h200, 16'hFFFE, 32'h0,        6'd10, 32'd0, 1, 0, 32'h0,  32'h12348765, 1, 1, 0, 32'hFFFF8765, 4'h0,    32'h0};
    tbl[8]  = '{LHU,  32'h200, 16'h0000, 32'h0,        6'd11, 32'd0, 1, 0, 32'h0,  32'h12348765, 0, 1, 0, 32'h00001234, 4'h0,    32'h0};
    tbl[9]  = '{SB,   32'h300, 16'h0001, 32'h5A,       6'd12, 32'd0, 1, 0, 32'h0,  32'h0,        2, 0, 0, 32'h0,        4'b0100, 32'h5A5A5A5A};
    tbl[10] = '{SW,   32'h400, 16'h0004, 32'hDEADBEEF, 6'd13, 32'd0, 1, 0, 32'h0,  32'h0,        0, 0, 0, 32'h0,        4'b1111, 32'hDEADBEEF};
    tbl[11] = '{LW,   32'h100, 16'h0002, 32'h0,        6'd5,  32'd0, 0, 1, 32'h88, 32'h0,        0, 0, 0, 32'h0,        4'h0,    32'h0};
    tbl[12] = '{LH,   32'h100, 16'h0001, 32'h0,        6'd5,  32'd0, 1, 0, 32'h0,  32'h0,        0, 0, 1, 32'h101,      4'h0,    32'h0};
    tbl[13] = '{SW,   32'h400, 16'h0006, 32'h1,        6'd5,  32'd0, 1, 0, 32'h0,  32'h0,        0, 0, 1, 32'h406,      4'h0,    32'h0};
    tbl[14] = '{LB,   32'h100, 16'h0000, 32'h0,        6'd14, 32'd0, 1, 0, 32'h0,  32'h7F8081FF, 1, 0, 0, 32'h0000007F, 4'h0,    32'h0};
    ops = '{LB, LH, LW, LBU, LHU, SB, SH, SW, ADDU, BEQ};

    idle_x();
    dmem.dmem_wait = 0; dmem.dmem_rvalid = 0; dmem.dmem_rdata = 0;
    rst = 1;
    repeat (2) @(negedge clock);
    chk("rst_valid", m_valid, 0);
    chk("rst_stall", m_stall, 0);
    chk("rst_req", dmem.dmem_req, 0);
    chk("rst_restart", m_restart, 0);
    chk("rst_restart_pc", m_restart_pc, 0);
    chk("rst_flush", m_flush, 0);
    chk("rst_res", m_res, 0);
    chk("rst_wbr", m_wbr, 0);
    chk("rst_badvaddr", m_badvaddr, 0);
    rst = 0;
    @(negedge clock);

    for (int i = 0; i < 15; i++) apply(tbl[i], 32'h1000 + i * 4);

    // Reset while waiting for load data abandons the access.
    x_valid = 1; x_opcode = LW; x_op1_val = 32'h500; x_instr = 32'h0; x_wbr = 6'd8;
    dmem.dmem_wait = 0;
    @(posedge clock); @(negedge clock);
    idle_x();
    @(posedge clock); @(negedge clock);
    chk("rstd_in_data", m_stall, 1);
    rst = 1;
    #1;
    chk("rstd_stall", m_stall, 0);
    chk("rstd_valid", m_valid, 0);
    chk("rstd_req", dmem.dmem_req, 0);
    @(negedge clock);
    rst = 0;
    dmem.dmem_rdata = 32'hCAFEF00D; dmem.dmem_rvalid = 1;
    @(posedge clock); @(negedge clock);
    dmem.dmem_rvalid = 0;
    chk("rstd_late_rvalid", m_valid, 0);
    chk("rstd_still_idle", m_stall, 0);

    for (int i = 0; i < 60; i++) begin
      v.op = ops[$urandom_range(0, 9)];
      v.base = $urandom; v.imm = 16'($urandom_range(0, 65535)); v.rt = $urandom;
      v.wbr = 6'($urandom_range(0, 31)); v.res = $urandom;
      v.valid = ($urandom_range(0, 9) != 0); v.restart = ($urandom_range(0, 4) == 0);
      v.rpc = $urandom; v.rdata = $urandom; v.waits = $urandom_range(0, 3);
      v.early_rv = 1'($urandom_range(0, 1));
      v = model(v);
      apply(v, 32'h2000 + i * 4);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
